// File: rtl/reset_sequencer.sv
// Power/reset sequencer for the VM1 core. Synchronised cold sources drive the DCLO/ACLO
// power sequence, and warm sources drive a timed peripheral init pulse.

module reset_sequencer_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end
endmodule

module reset_sequencer #(
  parameter int               N_SRC     = 4,
  parameter logic [N_SRC-1:0] COLD_MASK = 4'b0111,
  parameter int               DCLO_CLK  = 24,
  parameter int               ACLO_CLK  = 240,
  parameter int               LEAD_CLK  = 16,
  parameter int               INIT_CLK  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             cause_clr,
  output logic             dclo,
  output logic             aclo,
  output logic             init_out,
  output logic             ready,
  output logic [N_SRC-1:0] cause
);
  localparam int MAX_DA  = (DCLO_CLK > ACLO_CLK) ? DCLO_CLK : ACLO_CLK;
  localparam int MAX_LI  = (LEAD_CLK > INIT_CLK) ? LEAD_CLK : INIT_CLK;
  localparam int MAX_CLK = (MAX_DA > MAX_LI) ? MAX_DA : MAX_LI;
  localparam int CW      = $clog2(MAX_CLK + 1);

  localparam logic [CW-1:0] DCLO_END = CW'(DCLO_CLK - 1);
  localparam logic [CW-1:0] ACLO_END = CW'(ACLO_CLK - 1);
  localparam logic [CW-1:0] LEAD_END = CW'(LEAD_CLK - 1);
  localparam logic [CW-1:0] INIT_END = CW'(INIT_CLK - 1);

  localparam logic [1:0] ST_DCLO = 2'd0;
  localparam logic [1:0] ST_ACLO = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_LEAD = 2'd3;

  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] cold_bits, warm_bits;
  logic             cold_req, warm_req;

  logic [1:0]       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             dclo_d, aclo_d, init_d, ready_d;
  logic [N_SRC-1:0] cause_d;

  reset_sequencer_sync u_sync [N_SRC-1:0] (
    .clk   (clk),
    .reset (reset),
    .d     (src),
    .q     (s1)
  );

  assign cold_bits = s1 & COLD_MASK;
  assign warm_bits = s1 & ~COLD_MASK;
  assign cold_req  = |cold_bits;
  assign warm_req  = |warm_bits;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dclo_d  = dclo;
    aclo_d  = aclo;
    init_d  = init_out;
    // A set in the same cycle as a clear leaves only the new bits.
    cause_d = cause_clr ? '0 : cause;
    case (state)
      ST_DCLO: begin
        if (cold_req) begin
          cnt_d = '0;
        end else if (cnt == DCLO_END) begin
          state_d = ST_ACLO;
          cnt_d   = '0;
          dclo_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_ACLO: begin
        if (cold_req) begin
          state_d = ST_DCLO;
          cnt_d   = '0;
          dclo_d  = 1'b1;
        end else if (cnt == ACLO_END) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          aclo_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (cold_req) begin
          state_d = ST_LEAD;
          cnt_d   = '0;
          aclo_d  = 1'b1;
          init_d  = 1'b0;
          cause_d = cause_d | cold_bits;
        end else if (warm_req) begin
          init_d  = 1'b1;
          cnt_d   = '0;
          cause_d = cause_d | warm_bits;
        end else if (init_out) begin
          if (cnt == INIT_END) init_d = 1'b0;
          else                 cnt_d  = cnt + CW'(1);
        end
      end
      default: begin
        // Power-down is committed once the lead starts, even if the request drops.
        if (cnt == LEAD_END) begin
          state_d = ST_DCLO;
          cnt_d   = '0;
          dclo_d  = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
    endcase
    ready_d = (state_d == ST_RUN) && !init_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_DCLO;
      cnt      <= '0;
      dclo     <= 1'b1;
      aclo     <= 1'b1;
      init_out <= 1'b0;
      ready    <= 1'b0;
      cause    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      dclo     <= dclo_d;
      aclo     <= aclo_d;
      init_out <= init_d;
      ready    <= ready_d;
      cause    <= cause_d;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a remaining-time reference model predicts every
// cycle's outputs, and a separate monitor compares them against the DUT.

module tb_reset_sequencer;
  localparam int DCLO = 4, ACLO = 6, LEAD = 3, INIT = 5;
  localparam logic [3:0] CM = 4'b0111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src = '0;
  logic       cause_clr = 1'b0;
  logic       dclo, aclo, init_out, ready;
  logic [3:0] cause;

  reset_sequencer #(
    .N_SRC(4), .COLD_MASK(CM), .DCLO_CLK(DCLO), .ACLO_CLK(ACLO),
    .LEAD_CLK(LEAD), .INIT_CLK(INIT)
  ) dut (
    .clk(clk), .reset(reset), .src(src), .cause_clr(cause_clr),
    .dclo(dclo), .aclo(aclo), .init_out(init_out), .ready(ready), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dclo;
    logic       aclo;
    logic       init_out;
    logic       ready;
    logic [3:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;

  // Reference model: the outputs, plus the cycles left in each timed phase.
  logic       m_dclo, m_aclo, m_init;
  logic [3:0] m_cause;
  logic [3:0] h0, h1;
  int         dclo_left, aclo_left, lead_left, init_left;

  task automatic model_edge(input logic [3:0] s, input logic clr, input logic rst);
    logic [3:0] r;
    logic [3:0] nc;
    logic       cold, warm;
    exp_t       e;
    if (rst) begin
      h0 = '0; h1 = '0;
      m_dclo = 1'b1; m_aclo = 1'b1; m_init = 1'b0; m_cause = '0;
      dclo_left = DCLO; aclo_left = 0; lead_left = 0; init_left = 0;
    end else begin
      r = h1; h1 = h0; h0 = s;
      cold = |(r & CM);
      warm = |(r & ~CM);
      nc = clr ? 4'b0 : m_cause;
      if (m_dclo) begin
        if (cold) dclo_left = DCLO;
        else begin
          dclo_left--;
          if (dclo_left == 0) begin m_dclo = 1'b0; aclo_left = ACLO; end
        end
      end else if (m_aclo && lead_left > 0) begin
        lead_left--;
        if (lead_left == 0) begin m_dclo = 1'b1; dclo_left = DCLO; end
      end else if (m_aclo) begin
        if (cold) begin m_dclo = 1'b1; dclo_left = DCLO; end
        else begin
          aclo_left--;
          if (aclo_left == 0) m_aclo = 1'b0;
        end
      end else begin
        if (cold) begin
          m_aclo = 1'b1; lead_left = LEAD; m_init = 1'b0;
          nc = nc | (r & CM);
        end else if (warm) begin
          m_init = 1'b1; init_left = INIT;
          nc = nc | (r & ~CM);
        end else if (m_init) begin
          init_left--;
          if (init_left == 0) m_init = 1'b0;
        end
      end
      m_cause = nc;
    end
    e.dclo = m_dclo;
    e.aclo = m_aclo;
    e.init_out = m_init;
    e.ready = !m_dclo && !m_aclo && !m_init;
    e.cause = m_cause;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] s, input logic clr, input logic rst);
    @(negedge clk);
    src = s; cause_clr = clr; reset = rst;
    model_edge(s, clr, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {dclo, aclo, init_out, ready, cause};
        cyc++;
        n_chk++;
        if (g === e) n_pass++;
        else $display("FAIL outputs cycle %0d: dclo/aclo/init/ready/cause got %b expected %b",
                      cyc, g, e);
      end
    end
  end

  initial begin
    // Power-up from reset.
    step(4'b0, 1'b0, 1'b1);
    step(4'b0, 1'b0, 1'b1);
    idle(14);
    // Single-cycle cold pulse from RUN.
    step(4'b0001, 1'b0, 1'b0);
    idle(20);
    // Warm pulse, then retrigger while init is active.
    step(4'b1000, 1'b0, 1'b0);
    idle(10);
    step(4'b1000, 1'b0, 1'b0);
    idle(2);
    step(4'b1000, 1'b0, 1'b0);
    idle(8);
    // Cold request aborts a running init, then clear the cause.
    step(4'b1000, 1'b0, 1'b0);
    idle(2);
    step(4'b0010, 1'b0, 1'b0);
    idle(2);
    step(4'b0, 1'b1, 1'b0);
    // Hold a cold source during ACLO_WAIT.
    idle(8);
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0, 1'b0);
    idle(25);
    // Cold request held briefly, then dropped during PF_LEAD.
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    idle(20);
    // Reset during PF_LEAD, then reset during init.
    step(4'b0100, 1'b0, 1'b0);
    idle(3);
    step(4'b0, 1'b0, 1'b1);
    idle(20);
    step(4'b1000, 1'b0, 1'b0);
    idle(3);
    step(4'b0, 1'b0, 1'b1);
    idle(20);
    // Randomised traffic, including cause_clr colliding with new cause bits.
    for (int it = 0; it < 350; it++) begin
      int         kind;
      int         len;
      logic [3:0] s;
      logic       clr;
      logic       rst;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 6);
      s    = 4'b0;
      clr  = 1'b0;
      rst  = 1'b0;
      case (kind)
        0, 1, 2: len = $urandom_range(5, 30);
        3, 4:    s = 4'b1000;
        5:       s = 4'b0001 << $urandom_range(0, 2);
        6:       s = 4'($urandom_range(0, 15));
        7:       begin s = 4'($urandom_range(0, 15)); clr = 1'b1; len = 1; end
        8:       begin clr = 1'b1; len = 1; end
        default: begin rst = ($urandom_range(0, 3) == 0); len = 1; end
      endcase
      for (int k = 0; k < len; k++) step(s, clr, rst);
    end
    idle(3);
    @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power/reset sequencer for the VM1 CPU core, generalising the fixed DCLO/ACLO generator to N synchronised request sources. Each source is either cold or warm:
- Cold sources (button, PLL unlock, ROM-load wait) drive full power-down and power-up sequences on vm_dclo/vm_aclo, including an ACLO-before-DCLO power-fail lead for the CPU's power-fail trap.
- Warm sources (e.g. OSD reset, keyboard reset) produce a timed peripheral init pulse without touching DCLO/ACLO.
A sticky cause register records which sources triggered the last event.

Parameters:
N_SRC, 4, number of request sources.
COLD_MASK, 4'b0111, bit i=1: source i is cold; 0: source i is warm.
DCLO_CLK, 24, DCLO hold length in clk cycles after the last cold request cycle; must be ≥1.
ACLO_CLK, 240, additional ACLO hold after DCLO release; must be ≥1.
LEAD_CLK, 16, cycles ACLO leads DCLO on a power-down from RUN; must be ≥1.
INIT_CLK, 8, warm init pulse length; must be ≥1.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high.
src  in  N_SRC  asynchronous active-high reset requests, level-sensitive.
cause_clr  in  1  synchronous pulse; clears cause.
dclo  out  1  CPU DCLO, active-high.
aclo  out  1  CPU ACLO, active-high.
init_out  out  1  warm peripheral init, active-high.
ready  out  1  high in RUN with init_out low.
cause  out  N_SRC  sticky record of sources that started a sequence or init.

Behaviour:
- Synchroniser: every src bit passes through 2 flops (s0, s1).
  - cold_req = |(s1 & COLD_MASK); warm_req = |(s1 & ~COLD_MASK).
  - A src rising before edge k gives an FSM/output reaction registered at edge k+2.
- One counter, width $clog2(max(DCLO_CLK, ACLO_CLK, LEAD_CLK, INIT_CLK)+1). All outputs are registered.
- Reset, and the value on the cycle after reset: state=DCLO, cnt=0, dclo=1, aclo=1, init_out=0, ready=0, cause=0; synchroniser flops=0.
- States:
  - DCLO (dclo=1, aclo=1):
    - cold_req → cnt=0.
    - Otherwise cnt++.
    - When cnt==DCLO_CLK-1 and !cold_req → ACLO_WAIT, cnt=0, dclo=0.
    - Result: dclo is high for exactly DCLO_CLK cycles after the last cold_req cycle.
  - ACLO_WAIT (dclo=0, aclo=1):
    - cold_req → DCLO, cnt=0, dclo=1 on the next cycle.
    - Otherwise cnt++.
    - When cnt==ACLO_CLK-1 → RUN, aclo=0.
  - RUN (dclo=0, aclo=0):
    - cold_req → PF_LEAD, cnt=0, aclo=1, init_out=0 (cold beats warm; any running init is aborted).
    - Else warm_req → init_out=1, cnt=0. Retriggering while init is active restarts the count.
    - While init_out=1 and !warm_req: cnt++. At cnt==INIT_CLK-1 → init_out=0.
    - Result: the pulse lasts INIT_CLK cycles after the last warm_req cycle.
  - PF_LEAD (dclo=0, aclo=1):
    - cnt++ regardless of cold_req; the power-down is committed even if the request drops.
    - At cnt==LEAD_CLK-1 → DCLO, cnt=0, dclo=1.
- warm_req is ignored outside RUN; init_out=0 outside RUN.
- ready=1 iff state==RUN && !init_out, registered.
- cause:
  - On entry to PF_LEAD: cause |= s1 & COLD_MASK.
  - On an init (re)trigger in RUN: cause |= s1 & ~COLD_MASK.
  - cause_clr clears it next cycle. If cause_clr coincides with a set, the set wins: cause = new bits only.
- Mid-operation reset returns to the reset values immediately, including from PF_LEAD and during init.

Test Plan:
1. Params DCLO=4, ACLO=6, LEAD=3, INIT=5, src=0. Deassert reset → dclo falls after 4 cycles, aclo after 6 more; ready=1 on the next cycle; cause=0.
2. In RUN, pulse src[0] (cold) for 1 cycle → aclo=1 at +2 edges; dclo=1 exactly 3 cycles later; dclo 4 cycles, aclo 6 more; cause=4'b0001.
3. In RUN, src[3] (warm) high 1 cycle → init_out high exactly 5 cycles, dclo/aclo stay 0, ready low during pulse, cause=4'b1000. Retrigger at cycle 3 → pulse extends to 5 cycles after retrigger.
4. During init, assert src[1] (cold) → init_out drops, PF_LEAD entered, cause=4'b1010. Then cause_clr → cause=0.
5. Hold src[2] high 10 cycles during ACLO_WAIT → dclo reasserts immediately, stays high until 4 cycles after src[2] falls (plus 2 sync cycles). Drop cold request during PF_LEAD → sequence still completes.
6. Assert reset during PF_LEAD and during init → next cycle dclo=aclo=1, init_out=0, cause=0, then full power-up sequence as in scenario 1.
